// File: rtl/rv32i_de_skid_stage.sv
// Decode->execute elastic pipeline stage with a 2-entry skid buffer, flush and a
// saturating back-pressure counter. The bundle package lives alongside the stage.
package rv32i_de_pkg;

    typedef enum logic [3:0] {
        COND_NONE = 4'd0, COND_EQ, COND_NE, COND_LT, COND_GE, COND_LTU, COND_GEU
    } cond_code_t;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
    } alu_op_t;

    typedef enum logic [1:0] {
        MUX_WB_NONE = 2'd0, MUX_WB_ALU, MUX_WB_MEM, MUX_WB_PC4
    } mux_wb_t;

    typedef enum logic {MUX_A_RS1 = 1'b0, MUX_A_PC}  mux_a_t;
    typedef enum logic {MUX_B_RS2 = 1'b0, MUX_B_IMM} mux_b_t;

    typedef struct packed {
        logic [31:0] instruction_D;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        jump;
        logic        i_jump;
        logic        branch;
        logic        memory_transaction;
        logic        mem_write;
        logic        reg_write;
        cond_code_t  cond_code;
        alu_op_t     ALU_op;
        mux_wb_t     mux_writeback_select;
        mux_a_t      mux_operand_a;
        mux_b_t      mux_operand_b;
    } DE_pipe_bus_t;

    // Canonical no-op presented to execute whenever no live bundle is held.
    function automatic DE_pipe_bus_t de_bubble();
        DE_pipe_bus_t b;
        b                      = '0;
        b.instruction_D        = 32'h0000_0013;
        b.cond_code            = COND_NONE;
        b.ALU_op               = ALU_NONE;
        b.mux_writeback_select = MUX_WB_NONE;
        b.mux_operand_a        = MUX_A_RS1;
        b.mux_operand_b        = MUX_B_RS2;
        return b;
    endfunction

endpackage

module rv32i_de_skid_stage
    import rv32i_de_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  DE_pipe_bus_t           in_bus,
    output logic                   out_valid,
    input  logic                   out_ready,
    output DE_pipe_bus_t           out_bus,
    input  logic                   flush,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t       state, state_next;
    DE_pipe_bus_t main_q, main_d;
    DE_pipe_bus_t skid_q, skid_d;
    logic         accept, drain;

    // Every output is a function of registered state only, so execute's ready never
    // reaches decode combinationally.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_bus   = out_valid ? main_q : de_bubble();
    assign occupancy = (state == FULL) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= de_bubble();
            skid_q <= de_bubble();
        end else begin
            state  <= state_next;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    always_comb begin
        state_next = state;
        main_d     = main_q;
        skid_d     = skid_q;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    main_d     = in_bus;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_d = in_bus;
                end else if (accept) begin
                    skid_d     = in_bus;
                    state_next = FULL;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    main_d     = skid_q;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush wins over everything; stale data left in the registers is never shown.
        if (flush) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (in_valid && !in_ready && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv32i_de_skid_stage.sv
// Bench for rv32i_de_skid_stage: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rv32i_de_skid_stage;
    import rv32i_de_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    DE_pipe_bus_t     in_bus;
    logic             out_valid;
    logic             out_ready = 1'b0;
    DE_pipe_bus_t     out_bus;
    logic             flush = 1'b0;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_count;

    int tests = 0;
    int failures = 0;

    DE_pipe_bus_t mq[$];
    int unsigned  m_stall = 0;

    rv32i_de_skid_stage #(.STALL_CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
        .flush(flush), .occupancy(occupancy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic DE_pipe_bus_t make_bundle(input logic [7:0] tag);
        DE_pipe_bus_t b;
        b               = de_bubble();
        b.instruction_D = 32'hA000_0000 | {24'h0, tag};
        b.pc            = {22'h0, tag, 2'b00};
        b.rd_addr       = tag[4:0];
        b.reg_write     = 1'b1;
        b.ALU_op        = ALU_ADD;
        return b;
    endfunction

    function automatic DE_pipe_bus_t random_bundle();
        logic [255:0] raw;
        raw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return DE_pipe_bus_t'(raw[$bits(DE_pipe_bus_t)-1:0]);
    endfunction

    // Reference model: a bounded FIFO of at most two bundles, updated from the inputs at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_stall = 0;
        end else begin
            bit can_take, take, give;
            can_take = (mq.size() < 2);
            take     = in_valid && can_take;
            give     = (mq.size() > 0) && out_ready;
            if (in_valid && !can_take && m_stall < (2**CNT_W - 1))
                m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (give) void'(mq.pop_front());
                if (take) mq.push_back(in_bus);
            end
        end
    end

    always @(negedge clk) begin
        DE_pipe_bus_t exp_bus;
        exp_bus = (mq.size() > 0) ? mq[0] : de_bubble();
        check_output("cmp_in_ready",  in_ready,    mq.size() < 2);
        check_output("cmp_out_valid", out_valid,   mq.size() > 0);
        check_output("cmp_occupancy", occupancy,   mq.size());
        check_output("cmp_out_bus",   out_bus,     exp_bus);
        check_output("cmp_stall",     stall_count, m_stall);
    end

    task automatic apply_stimulus(input logic v, input DE_pipe_bus_t b, input logic r, input logic f);
        in_valid  = v;
        in_bus    = b;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        DE_pipe_bus_t a, b, c, bub;
        a   = make_bundle(8'h0A);
        b   = make_bundle(8'h0B);
        c   = make_bundle(8'h0C);
        bub = de_bubble();
        in_bus = bub;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_in_ready",  in_ready,   1'b1);
        check_output("reset_out_valid", out_valid,  1'b0);
        check_output("reset_occupancy", occupancy,  2'd0);
        check_output("reset_stall",     stall_count, 4'd0);
        check_output("reset_bus_instr", out_bus.instruction_D, 32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming
        apply_stimulus(1, a, 1, 0);
        check_output("stream_a",   out_bus.instruction_D, 32'hA000_000A);
        check_output("stream_occ", occupancy, 2'd1);
        apply_stimulus(1, b, 1, 0);
        check_output("stream_b",   out_bus.instruction_D, 32'hA000_000B);
        apply_stimulus(1, c, 1, 0);
        check_output("stream_c",   out_bus.instruction_D, 32'hA000_000C);
        check_output("stream_occ_c", occupancy, 2'd1);
        apply_stimulus(0, bub, 1, 0);
        check_output("stream_empty", out_valid, 1'b0);

        // Back-pressure
        apply_stimulus(1, a, 0, 0);
        apply_stimulus(1, b, 0, 0);
        check_output("bp_full_occ",   occupancy, 2'd2);
        check_output("bp_full_ready", in_ready, 1'b0);
        apply_stimulus(1, c, 0, 0);
        apply_stimulus(1, c, 0, 0);
        check_output("bp_stall2", stall_count, 4'd2);
        check_output("bp_head_a", out_bus.instruction_D, 32'hA000_000A);
        apply_stimulus(1, c, 1, 0);
        check_output("bp_head_b", out_bus.instruction_D, 32'hA000_000B);
        check_output("bp_stall3", stall_count, 4'd3);
        apply_stimulus(1, c, 1, 0);
        check_output("bp_head_c", out_bus.instruction_D, 32'hA000_000C);
        apply_stimulus(0, bub, 1, 0);
        check_output("bp_drained", occupancy, 2'd0);

        // Flush while FULL with a simultaneous offer
        apply_stimulus(1, a, 0, 0);
        apply_stimulus(1, b, 0, 0);
        apply_stimulus(1, c, 0, 1);
        check_output("flush_occ",       occupancy, 2'd0);
        check_output("flush_valid",     out_valid, 1'b0);
        check_output("flush_bus",       out_bus, bub);
        check_output("flush_instr",     out_bus.instruction_D, 32'h0000_0013);
        check_output("flush_reg_write", out_bus.reg_write, 1'b0);
        apply_stimulus(0, bub, 1, 0);
        apply_stimulus(0, bub, 1, 0);
        check_output("flush_no_c", out_valid, 1'b0);

        // Async reset mid-cycle while FULL and stalling
        apply_stimulus(1, a, 0, 0);
        apply_stimulus(1, b, 0, 0);
        apply_stimulus(1, c, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("areset_ready", in_ready, 1'b1);
        check_output("areset_valid", out_valid, 1'b0);
        check_output("areset_occ",   occupancy, 2'd0);
        check_output("areset_stall", stall_count, 4'd0);
        check_output("areset_bus",   out_bus, bub);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1, a, 0, 0);
        check_output("areset_first_accept", out_bus.instruction_D, 32'hA000_000A);

        // Saturation: already holding A, fill then stall for 20 edges
        apply_stimulus(1, b, 0, 0);
        for (int i = 0; i < 14; i++) apply_stimulus(1, c, 0, 0);
        check_output("sat_14", stall_count, 4'd14);
        for (int i = 0; i < 6; i++) apply_stimulus(1, c, 0, 0);
        check_output("sat_15", stall_count, 4'd15);
        apply_stimulus(0, bub, 1, 0);
        apply_stimulus(0, bub, 1, 0);
        check_output("sat_hold", stall_count, 4'd15);

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            apply_stimulus($urandom_range(0, 9) < 6, random_bundle(),
                           $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
        end
        apply_stimulus(0, bub, 1, 0);
        apply_stimulus(0, bub, 1, 0);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
